// File: rtl/spi_deserializer.sv
// SPI receive deserializer: synchronizes and oversamples sclk/mosi/cs_n in the
// clk domain and assembles MSB-first words. Each word is written to the
// receive FIFO with a single-cycle strobe.
module spi_deserializer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    input  logic                  full,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  done,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic                    sclk_d;
    logic                    cs_d;

    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [CNT_W-1:0]        bit_cnt;

    logic                    sclk_s;
    logic                    mosi_s;
    logic                    cs_s;
    logic                    sclk_rise;
    logic                    cs_rise;
    logic                    shift_en;
    logic                    word_last;

    logic                    write_en_nxt;
    logic                    overrun_nxt;
    logic                    frame_err_nxt;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign shift_en  = sclk_rise & ~cs_s;
    assign word_last = shift_en && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    // Equal-depth synchronizers keep sclk, mosi and cs_n aligned; one extra
    // flop on sclk and cs_n provides edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Shift datapath runs regardless of FSM state; an idle frame select
    // discards any partial word and holds the bit counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
        end else if (cs_s) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
            if (word_last) begin
                hold_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
                bit_cnt  <= '0;
            end else begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; completion always wins over cs_n.
    always_comb begin
        state_nxt     = state;
        write_en_nxt  = 1'b0;
        overrun_nxt   = 1'b0;
        frame_err_nxt = cs_rise && (bit_cnt != '0);
        case (state)
            IDLE: begin
                if (word_last) begin
                    state_nxt = STORE;
                end else if (!cs_s) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (word_last) begin
                    state_nxt = STORE;
                end else if (cs_s) begin
                    state_nxt = IDLE;
                end
            end
            STORE: begin
                if (full) begin
                    overrun_nxt  = 1'b1;
                end else begin
                    write_en_nxt = 1'b1;
                end
                if (word_last) begin
                    state_nxt = STORE;
                end else if (cs_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered FIFO-side outputs; write_data holds between accepted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            write_data <= '0;
        end else begin
            write_en  <= write_en_nxt;
            done      <= write_en_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
            if (write_en_nxt) begin
                write_data <= hold_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer: directed table, hand sequences
// for reset / idle / latency corners, and random frames against a word model.
module tb_spi_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       full = 1'b0;
    logic       write_en;
    logic [7:0] write_data;
    logic       done;
    logic       overrun;
    logic       frame_err;

    spi_deserializer #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .full       (full),
        .write_en   (write_en),
        .write_data (write_data),
        .done       (done),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor totals (written only by the monitor).
    int         tot_w = 0;
    int         tot_o = 0;
    int         tot_f = 0;
    int         bad_both = 0;
    int         bad_done = 0;
    int         bad_cnt = 0;
    int         last_wr_cyc = -1;
    logic [7:0] got_q[$];

    int last_rise_cyc = 0;
    bit idle_test = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (write_en) begin
                tot_w++;
                got_q.push_back(write_data);
                last_wr_cyc = cyc;
            end
            if (overrun)               tot_o++;
            if (frame_err)             tot_f++;
            if (write_en && overrun)   bad_both++;
            if (done != write_en)      bad_done++;
            if (idle_test && dut.bit_cnt != '0) bad_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        mosi = b;
        tick(2);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        tick(2);
    endtask

    // One frame: cs_n low, nbits MSB-first bits, then cs_n high and settle.
    task automatic send_frame(input logic [31:0] bits, input int nbits, input logic f);
        full = f;
        cs_n = 1'b0;
        tick(3);
        for (int i = 0; i < nbits; i++) begin
            logic [31:0] tmp;
            tmp = bits >> (nbits - 1 - i);
            send_bit(tmp[0]);
        end
        tick(8);
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(8);
        full = 1'b0;
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic        full;
        int          exp_w;
        int          exp_o;
        int          exp_f;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] last_data;

    initial begin
        int w0, o0, f0;

        vecs[0] = '{32'h0000_00A5,  8, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{32'h0000_3CC3, 16, 1'b0, 2, 0, 0, 8'hC3};
        vecs[2] = '{32'h0000_005A,  8, 1'b1, 0, 1, 0, 8'hC3};
        vecs[3] = '{32'h0000_0077,  8, 1'b0, 1, 0, 0, 8'h77};
        vecs[4] = '{32'h0000_0016,  5, 1'b0, 0, 0, 1, 8'h77};
        vecs[5] = '{32'h0000_00FF,  8, 1'b0, 1, 0, 0, 8'hFF};

        // Reset state.
        tick(3);
        @(negedge clk);
        check("reset_outs", int'({write_en, done, overrun, frame_err, write_data}), 0);
        check("reset_state", int'({2'(dut.state), dut.bit_cnt}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(6);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            w0 = tot_w; o0 = tot_o; f0 = tot_f;
            send_frame(vecs[v].bits, vecs[v].nbits, vecs[v].full);
            check($sformatf("vec%0d_writes", v),   tot_w - w0, vecs[v].exp_w);
            check($sformatf("vec%0d_overrun", v),  tot_o - o0, vecs[v].exp_o);
            check($sformatf("vec%0d_frame_err", v), tot_f - f0, vecs[v].exp_f);
            check($sformatf("vec%0d_data", v),     int'(write_data), int'(vecs[v].exp_data));
            if (v == 0) begin
                check("latency_a5", last_wr_cyc - last_rise_cyc, 4);
            end
            if (v == 1) begin
                check("b2b_first", (got_q.size() >= 2) ? int'(got_q[got_q.size()-2]) : -1, 8'h3C);
            end
        end
        last_data = write_data;

        // Reset asserted after 3 bits of a word.
        w0 = tot_w; f0 = tot_f;
        cs_n = 1'b0;
        tick(3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", int'({write_en, done, overrun, frame_err, write_data}), 0);
        check("midrst_state", int'({2'(dut.state), dut.bit_cnt}), 0);
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        send_frame(32'h81, 8, 1'b0);
        check("midrst_writes", tot_w - w0, 1);
        check("midrst_frame_err", tot_f - f0, 0);
        check("midrst_data", int'(write_data), 8'h81);

        // sclk activity with cs_n high is ignored.
        w0 = tot_w; o0 = tot_o; f0 = tot_f;
        idle_test = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        sclk = 1'b0;
        tick(6);
        idle_test = 1'b0;
        check("idle_events", (tot_w - w0) + (tot_o - o0) + (tot_f - f0), 0);
        check("idle_bit_cnt", bad_cnt, 0);

        // Random frames against the word-level model.
        got_q.delete();
        exp_q.delete();
        last_data = write_data;
        for (int r = 0; r < 20; r++) begin
            logic [31:0] bits;
            int          nb;
            logic        f;
            int          nw;
            bits = $urandom;
            nb   = $urandom_range(1, 24);
            f    = 1'($urandom_range(0, 3) == 0);
            nw   = nb / 8;
            w0 = tot_w; o0 = tot_o; f0 = tot_f;
            for (int k = 0; k < nw; k++) begin
                logic [31:0] wv;
                wv = bits >> (nb - 8 * (k + 1));
                if (!f) begin
                    exp_q.push_back(wv[7:0]);
                    last_data = wv[7:0];
                end
            end
            send_frame(bits, nb, f);
            check($sformatf("rnd%0d_writes", r),  tot_w - w0, f ? 0 : nw);
            check($sformatf("rnd%0d_overrun", r), tot_o - o0, f ? nw : 0);
            check($sformatf("rnd%0d_frame_err", r), tot_f - f0, (nb % 8 != 0) ? 1 : 0);
            check($sformatf("rnd%0d_data", r),    int'(write_data), int'(last_data));
        end
        check("rnd_word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rnd_word%0d", i), int'(got_q[i]), int'(exp_q[i]));
        end

        check("wr_and_overrun", bad_both, 0);
        check("done_eq_write_en", bad_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
